uart_rx_cfg: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8-bit receiver. It takes the asynchronous serial line, oversamples it with a per-bit clock counter and majority-votes each bit. It checks start, parity and stop bits and presents each received word on a valid/ready handshake with error flags. It sits between the board RX pin and the word-assembly logic that builds 32-bit words from received bytes.

---
 rtl/uart_rx_cfg.sv | 150 +++++++++++++++
 tb/tb_uart_rx_cfg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - Parametrised oversampling UART receiver with valid/ready word output
// Majority-votes three mid-bit samples per bit; completes each frame at the final stop vote.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_VOTE = CW'(HALF + 1);
  localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q;
  logic                 vote, vote_now, bit_end, last_stop, done, fe_final;

  assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign vote_now  = (cnt == CNT_VOTE);
  assign bit_end   = (cnt == CNT_LAST);
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign done      = (state == STOP) && vote_now && last_stop;
  assign fe_final  = ferr_q | ~vote;

  // sync_fill keeps the reset value of the synchroniser from arming the receiver
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
        if (cnt == CNT_S0) s0 <= rx_s;
        if (cnt == CNT_S1) s1 <= rx_s;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (armed && !rx_s) begin
            armed    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            stop_idx <= 1'b0;
            state    <= START;
          end else if (sync_fill[1] && rx_s) begin
            armed <= 1'b1;
          end
        end
        START: begin
          if (vote_now && vote) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (bit_end) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == IDX_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (vote_now) perr_q <= vote ^ (^shreg) ^ ODD;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (vote_now && !vote) ferr_q <= 1'b1;
          if (done) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (bit_end) begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // a held, unaccepted word wins over a newly completed frame
      if (done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          parity_err <= perr_q;
          frame_err  <= fe_final;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        break_det <= (shreg == '0) && fe_final;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - Self-checking bench for uart_rx_cfg in 8N1, 8E1 and 7O2 configurations
// Frames are built from data/parity/stop rules; expected words, flags and timing come from a frame model.
module tb_uart_rx_cfg;
  localparam int CPB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       rx_l [3];
  logic       rdy  [3];
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       v [3], pe [3], fe [3], ov [3], bk [3];
  logic [8:0] dw [3];

  int nd    [3] = '{8, 8, 7};
  int pen   [3] = '{0, 1, 1};
  int podd  [3] = '{0, 0, 1};
  int nstop [3] = '{1, 1, 2};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcnt [3], first_v [3], ovr_n [3], brk_n [3];
  logic vprev [3];

  assign dw[0] = {1'b0, d0};
  assign dw[1] = {1'b0, d1};
  assign dw[2] = {2'b00, d2};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rx(rx_l[0]), .data_out(d0), .data_valid(v[0]), .data_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .break_det(bk[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rx(rx_l[1]), .data_out(d1), .data_valid(v[1]), .data_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .break_det(bk[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset(reset), .rx(rx_l[2]), .data_out(d2), .data_valid(v[2]), .data_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .break_det(bk[2]));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v[i] === 1'b1) vcnt[i]++;
      if (v[i] === 1'b1 && vprev[i] !== 1'b1 && first_v[i] < 0) first_v[i] = cyc;
      if (ov[i] === 1'b1) ovr_n[i]++;
      if (bk[i] === 1'b1) brk_n[i]++;
      vprev[i] = v[i];
    end
  end

  task automatic clr(input int i);
    vcnt[i] = 0; first_v[i] = -1; ovr_n[i] = 0; brk_n[i] = 0;
  endtask

  function automatic int exp_cyc(input int i, input int c0);
    return c0 + 3 + (nd[i] + pen[i] + nstop[i]) * CPB + CPB / 2 + 2;
  endfunction

  task automatic send(input int i, input logic [8:0] d, input bit flip_par,
                      input logic [1:0] stops, output int c0);
    logic [15:0] bits;
    logic        p;
    int          n;
    bits = '0; n = 1; p = 1'b0;
    for (int b = 0; b < nd[i]; b++) begin bits[n] = d[b]; p = p ^ d[b]; n++; end
    if (pen[i] != 0) begin bits[n] = p ^ (podd[i] != 0) ^ flip_par; n++; end
    for (int s = 0; s < nstop[i]; s++) begin bits[n] = stops[s]; n++; end
    @(posedge clk); #1;
    c0 = cyc;
    for (int b = 0; b < n; b++) begin
      rx_l[i] = bits[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_l[i] = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin rx_l[i] = 1'b1; rdy[i] = 1'b1; clr(i); vprev[i] = 1'b0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dw[i] !== 9'h000) begin errors++; $display("FAIL reset_data[%0d] got=%0h exp=0", i, dw[i]); end
      checks++; if ({v[i], pe[i], fe[i], ov[i], bk[i]} !== 5'b0) begin
        errors++; $display("FAIL reset_flags[%0d] got=%b exp=00000", i, {v[i], pe[i], fe[i], ov[i], bk[i]}); end
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_8n1;
    int c0;
    clr(0);
    send(0, 9'h0A5, 1'b0, 2'b11, c0);
    repeat (20) @(posedge clk);
    checks++; if (dw[0] !== 9'h0A5) begin errors++; $display("FAIL 8n1_data got=%0h exp=a5", dw[0]); end
    checks++; if (pe[0] !== 1'b0 || fe[0] !== 1'b0) begin errors++; $display("FAIL 8n1_flags got=%b%b exp=00", pe[0], fe[0]); end
    checks++; if (vcnt[0] !== 1) begin errors++; $display("FAIL 8n1_valid_len got=%0d exp=1", vcnt[0]); end
    checks++; if (first_v[0] !== exp_cyc(0, c0)) begin
      errors++; $display("FAIL 8n1_latency got=%0d exp=%0d", first_v[0] - c0 - 3, exp_cyc(0, c0) - c0 - 3); end
  endtask

  task automatic test_parity;
    int c0;
    clr(1);
    send(1, 9'h03C, 1'b1, 2'b11, c0);
    repeat (10) @(posedge clk);
    checks++; if (dw[1] !== 9'h03C) begin errors++; $display("FAIL par_data got=%0h exp=3c", dw[1]); end
    checks++; if (pe[1] !== 1'b1) begin errors++; $display("FAIL par_err_bad got=%b exp=1", pe[1]); end
    send(1, 9'h03C, 1'b0, 2'b11, c0);
    repeat (10) @(posedge clk);
    checks++; if (pe[1] !== 1'b0) begin errors++; $display("FAIL par_err_good got=%b exp=0", pe[1]); end
  endtask

  task automatic test_stop;
    int c0;
    clr(2);
    send(2, 9'h055, 1'b0, 2'b01, c0);
    repeat (10) @(posedge clk);
    checks++; if (dw[2] !== 9'h055) begin errors++; $display("FAIL stop_data got=%0h exp=55", dw[2]); end
    checks++; if (fe[2] !== 1'b1 || pe[2] !== 1'b0) begin errors++; $display("FAIL stop2_bad got=fe%b pe%b exp=fe1 pe0", fe[2], pe[2]); end
    send(2, 9'h055, 1'b0, 2'b11, c0);
    repeat (10) @(posedge clk);
    checks++; if (fe[2] !== 1'b0) begin errors++; $display("FAIL stop2_good got=%b exp=0", fe[2]); end
    checks++; if (vcnt[2] !== 2) begin errors++; $display("FAIL stop_count got=%0d exp=2", vcnt[2]); end
  endtask

  task automatic test_glitch;
    int c0;
    clr(0);
    @(posedge clk); #1 rx_l[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx_l[0] = 1'b1;
    repeat (100) @(posedge clk);
    checks++; if (vcnt[0] !== 0) begin errors++; $display("FAIL glitch_novalid got=%0d exp=0", vcnt[0]); end
    send(0, 9'h081, 1'b0, 2'b11, c0);
    repeat (10) @(posedge clk);
    checks++; if (dw[0] !== 9'h081 || vcnt[0] !== 1) begin
      errors++; $display("FAIL glitch_next got=%0h/%0d exp=81/1", dw[0], vcnt[0]); end
  endtask

  task automatic test_back_to_back_overrun;
    int c0;
    clr(0);
    rdy[0] = 1'b0;
    send(0, 9'h011, 1'b0, 2'b11, c0);
    send(0, 9'h022, 1'b0, 2'b11, c0);
    repeat (10) @(posedge clk);
    checks++; if (dw[0] !== 9'h011 || v[0] !== 1'b1) begin errors++; $display("FAIL ovr_hold got=%0h v%b exp=11 v1", dw[0], v[0]); end
    checks++; if (ovr_n[0] !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_n[0]); end
    @(posedge clk); #1 rdy[0] = 1'b1;
    @(negedge clk);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL ovr_pre_accept got=%b exp=1", v[0]); end
    @(negedge clk);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%b exp=0", v[0]); end
  endtask

  task automatic test_break;
    int c0;
    clr(0);
    @(posedge clk); #1 rx_l[0] = 1'b0;
    c0 = cyc;
    repeat (3 * 10 * CPB) @(posedge clk);
    #1 rx_l[0] = 1'b1;
    repeat (100) @(posedge clk);
    checks++; if (vcnt[0] !== 1) begin errors++; $display("FAIL brk_frames got=%0d exp=1", vcnt[0]); end
    checks++; if (dw[0] !== 9'h000 || fe[0] !== 1'b1) begin errors++; $display("FAIL brk_word got=%0h fe%b exp=0 fe1", dw[0], fe[0]); end
    checks++; if (brk_n[0] !== 1) begin errors++; $display("FAIL brk_pulse got=%0d exp=1", brk_n[0]); end
    checks++; if (first_v[0] !== exp_cyc(0, c0)) begin errors++; $display("FAIL brk_time got=%0d exp=%0d", first_v[0], exp_cyc(0, c0)); end
  endtask

  task automatic test_reset_mid;
    int c0;
    rdy[0] = 1'b0;
    send(0, 9'h05A, 1'b0, 2'b11, c0);
    repeat (5) @(posedge clk);
    @(posedge clk); #1 rx_l[0] = 1'b0;
    repeat (100) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (v[0] !== 1'b0 || dw[0] !== 9'h000 || fe[0] !== 1'b0 || pe[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_clear got=v%b d%0h fe%b pe%b exp=all 0", v[0], dw[0], fe[0], pe[0]); end
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    clr(0);
    rdy[0] = 1'b1;
    repeat (200) @(posedge clk);
    #1 rx_l[0] = 1'b1;
    repeat (60) @(posedge clk);
    send(0, 9'h0F0, 1'b0, 2'b11, c0);
    repeat (10) @(posedge clk);
    checks++; if (dw[0] !== 9'h0F0 || vcnt[0] !== 1 || fe[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_next got=%0h/%0d fe%b exp=f0/1 fe0", dw[0], vcnt[0], fe[0]); end
  endtask

  task automatic test_random;
    int c0, i;
    logic [8:0] d;
    bit flip, fe_x, brk_x;
    logic [1:0] stops;
    for (int rep = 0; rep < 6; rep++) begin
      i = $urandom_range(0, 2);
      d = 9'($urandom_range(0, (1 << nd[i]) - 1));
      flip = (pen[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      stops = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      fe_x = (stops[0] == 1'b0) || (nstop[i] == 2 && stops[1] == 1'b0);
      brk_x = (d == 9'h000) && fe_x;
      clr(i);
      send(i, d, flip, stops, c0);
      repeat (10) @(posedge clk);
      checks++; if (dw[i] !== d || pe[i] !== flip || fe[i] !== fe_x) begin
        errors++; $display("FAIL rand[%0d]_word got=%0h pe%b fe%b exp=%0h pe%b fe%b", i, dw[i], pe[i], fe[i], d, flip, fe_x); end
      checks++; if (vcnt[i] !== 1 || first_v[i] !== exp_cyc(i, c0) || brk_n[i] !== int'(brk_x)) begin
        errors++; $display("FAIL rand[%0d]_timing got=n%0d t%0d b%0d exp=n1 t%0d b%0d", i, vcnt[i], first_v[i], brk_n[i], exp_cyc(i, c0), brk_x); end
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_stop;
    test_glitch;
    test_back_to_back_overrun;
    test_break;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
